// File: rtl/osf_pkg.sv
// Shared definitions for the oversampling averager: channel states, default ratio cap,
// accumulator sizing and the oversample-ratio clamp.
package osf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_ACCUM   = 2'd2
    } osf_state_e;

    localparam int OSM_MAX_DEF = 10;

    // Holds 2^osm_max full-scale samples without wrapping.
    function automatic int acc_width(input int w_adc, input int osm_max);
        return w_adc + osm_max;
    endfunction

    function automatic int clamp_osm(input int osm, input int osm_max);
        return (osm > osm_max) ? osm_max : osm;
    endfunction

endpackage

// File: rtl/oversample_filter_if.sv
// Sample, parameter-staging and result bus between ADC controller, host and PID stage.
// No backpressure: all strobes are single-cycle and must be consumed when seen.
interface oversample_filter_if #(
    parameter int N_CHAN    = 8,
    parameter int W_ADC     = 18,
    parameter int W_OSF_CD  = 16,
    parameter int W_OSF_OSM = 6
);
    logic [N_CHAN-1:0]       data_valid_in;
    logic [N_CHAN*W_ADC-1:0] data_in;
    logic [N_CHAN-1:0]       activate_in;
    logic [W_OSF_CD-1:0]     cycle_delay_in;
    logic [W_OSF_OSM-1:0]    osm_in;
    logic [N_CHAN-1:0]       update_en_in;
    logic                    module_update_in;
    logic [N_CHAN-1:0]       data_valid_out;
    logic [N_CHAN*W_ADC-1:0] data_out;

    modport master (
        output data_valid_in, data_in, activate_in, cycle_delay_in, osm_in,
               update_en_in, module_update_in,
        input  data_valid_out, data_out
    );

    modport slave (
        input  data_valid_in, data_in, activate_in, cycle_delay_in, osm_in,
               update_en_in, module_update_in,
        output data_valid_out, data_out
    );
endinterface

// File: rtl/osf_channel.sv
// One channel: hold-off, accumulate 2^osm samples, emit mean 1 cycle after the last sample.
// No backpressure; OSF_ROUND_EN selects round-half-up with saturation instead of floor.
module osf_channel
    import osf_pkg::*;
#(
    parameter int W_ADC     = 18,
    parameter int W_OSF_CD  = 16,
    parameter int W_OSF_OSM = 6,
    parameter int OSM_MAX   = OSM_MAX_DEF
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    sample_vld,
    input  logic signed [W_ADC-1:0] sample_dat,
    input  logic                    activate,
    input  logic [W_OSF_CD-1:0]     cd_stage,
    input  logic [W_OSF_OSM-1:0]    osm_stage,
    input  logic                    commit,
    output logic                    out_vld,
    output logic [W_ADC-1:0]        out_dat
);
    localparam int W_ACC = acc_width(W_ADC, OSM_MAX);
    localparam int W_OSM = $clog2(OSM_MAX + 1);
    localparam int W_CNT = OSM_MAX + 1;

    osf_state_e                 state_q, state_d;
    logic signed [W_ACC-1:0]    acc_q, acc_d;
    logic [W_CNT-1:0]           cnt_q, cnt_d;
    logic [W_OSF_CD-1:0]        dcnt_q, dcnt_d;
    logic [W_OSF_CD-1:0]        cd_q, cd_d;
    logic [W_OSM-1:0]           osm_q, osm_d;
    logic [W_ADC-1:0]           dout_q, dout_d;
    logic                       dvld_q, dvld_d;

    logic signed [W_ACC-1:0]    sample_ext;
    logic signed [W_ACC-1:0]    sum;
    logic [W_ADC-1:0]           result;
    logic                       last_sample;

    assign sample_ext  = {{(W_ACC-W_ADC){sample_dat[W_ADC-1]}}, sample_dat};
    assign sum         = acc_q + sample_ext;
    assign last_sample = (cnt_q == ((W_CNT'(1) << osm_q) - W_CNT'(1)));

`ifdef OSF_ROUND_EN
    localparam logic signed [W_ACC:0] SAT_MAX = signed'((W_ACC+1)'((2 ** (W_ADC-1)) - 1));
    logic signed [W_ACC:0] rnd_sum;
    logic signed [W_ACC:0] rnd_shift;

    always_comb begin
        rnd_sum = {sum[W_ACC-1], sum};
        if (osm_q != '0) begin
            rnd_sum = rnd_sum + signed'((W_ACC+1)'(1) << (osm_q - W_OSM'(1)));
        end
        rnd_shift = rnd_sum >>> osm_q;
        // Only a positive half-step can push the mean past full scale.
        if (rnd_shift > SAT_MAX) begin
            result = SAT_MAX[W_ADC-1:0];
        end else begin
            result = rnd_shift[W_ADC-1:0];
        end
    end
`else
    logic signed [W_ACC-1:0] shifted;

    assign shifted = sum >>> osm_q;
    assign result  = shifted[W_ADC-1:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        cd_d    = cd_q;
        osm_d   = osm_q;
        dout_d  = dout_q;
        dvld_d  = 1'b0;

        if (commit) begin
            osm_d = W_OSM'(clamp_osm(int'(osm_stage), OSM_MAX));
            cd_d  = cd_stage;
        end

        if (!activate) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (commit) begin
            // A commit wins over a coincident final sample: the block is abandoned.
            acc_d   = '0;
            cnt_d   = '0;
            dcnt_d  = cd_stage;
            state_d = (cd_stage == '0) ? ST_ACCUM : ST_HOLDOFF;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    dcnt_d  = cd_q;
                    state_d = (cd_q == '0) ? ST_ACCUM : ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    dcnt_d = dcnt_q - W_OSF_CD'(1);
                    if (dcnt_q <= W_OSF_CD'(1)) begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (sample_vld) begin
                        if (last_sample) begin
                            dout_d  = result;
                            dvld_d  = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                            dcnt_d  = cd_q;
                            state_d = (cd_q == '0) ? ST_ACCUM : ST_HOLDOFF;
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_q + W_CNT'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            cd_q    <= '0;
            osm_q   <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            cd_q    <= cd_d;
            osm_q   <= osm_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
        end
    end

    assign out_vld = dvld_q;
    assign out_dat = dout_q;

endmodule

// File: rtl/oversample_filter.sv
// Per-channel oversampling averager, N_CHAN independent channels, result 1 cycle after last sample.
// No backpressure; rounding mode selected by OSF_ROUND_EN inside each channel.
module oversample_filter
    import osf_pkg::*;
#(
    parameter int N_CHAN    = 8,
    parameter int W_ADC     = 18,
    parameter int W_OSF_CD  = 16,
    parameter int W_OSF_OSM = 6,
    parameter int OSM_MAX   = OSM_MAX_DEF
) (
    input  logic          clk_in,
    input  logic          reset_in,
    oversample_filter_if.slave bus
);
    logic [N_CHAN-1:0]       vld_out;
    logic [N_CHAN*W_ADC-1:0] dat_out;

    for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
        osf_channel #(
            .W_ADC     (W_ADC),
            .W_OSF_CD  (W_OSF_CD),
            .W_OSF_OSM (W_OSF_OSM),
            .OSM_MAX   (OSM_MAX)
        ) u_chan (
            .clk_in     (clk_in),
            .reset_in   (reset_in),
            .sample_vld (bus.data_valid_in[k]),
            .sample_dat (bus.data_in[k*W_ADC +: W_ADC]),
            .activate   (bus.activate_in[k]),
            .cd_stage   (bus.cycle_delay_in),
            .osm_stage  (bus.osm_in),
            .commit     (bus.module_update_in & bus.update_en_in[k]),
            .out_vld    (vld_out[k]),
            .out_dat    (dat_out[k*W_ADC +: W_ADC])
        );
    end

    assign bus.data_valid_out = vld_out;
    assign bus.data_out       = dat_out;

endmodule
